// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the two-requester FIFO write arbiter.
// State encoding is fixed so that other blocks can decode it directly.
package fifo_ctrl_pkg;

  localparam int FIFO_DEPTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  // Grant decision for one cycle: vld = a write issues, idx = which requester.
  typedef struct packed {
    logic vld;
    logic idx;
  } grant_t;

endpackage

// File: rtl/fifo_occ_counter.sv
// Occupancy tracking for the controlled FIFO: count, full/empty decode,
// registered read strobe and one-cycle overflow/underflow error pulses.
module fifo_occ_counter
  import fifo_ctrl_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH_DEF,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_issue,
  input  logic          rd_en,
  input  logic          any_req,
  output logic [CW-1:0] data_count,
  output logic          full,
  output logic          empty,
  output logic          fifo_rd_en,
  output logic          wr_err,
  output logic          rd_err
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic rd_issue;

  assign full     = (data_count == FULL_CNT);
  assign empty    = (data_count == '0);
  assign rd_issue = rd_en && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_count <= '0;
      fifo_rd_en <= 1'b0;
      wr_err     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      fifo_rd_en <= rd_issue;
      wr_err     <= any_req && full;
      rd_err     <= rd_en && empty;
      // The arbiter never issues a write at full, so a read in the same
      // cycle cannot open a slot for a write-through.
      case ({wr_issue, rd_issue})
        2'b10:   data_count <= data_count + CW'(1);
        2'b01:   data_count <= data_count - CW'(1);
        default: data_count <= data_count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Two-requester write arbiter in front of a FIFO: no back-to-back grants to
// the same requester, round-robin on contention, occupancy-gated writes.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req0,
  input  logic                    req1,
  input  logic [DATA_WIDTH-1:0]   din0,
  input  logic [DATA_WIDTH-1:0]   din1,
  output logic                    gnt0,
  output logic                    gnt1,
  input  logic                    rd_en,
  output logic                    fifo_wr_en,
  output logic                    fifo_rd_en,
  output logic [DATA_WIDTH-1:0]   fifo_din,
  output logic [$clog2(DEPTH):0]  data_count,
  output logic                    full,
  output logic                    empty,
  output logic                    wr_err,
  output logic                    rd_err
);

  arb_state_t state_q, state_d;
  logic       lgp_q, lgp_d;
  logic [1:0] elig;
  grant_t     gnt_d;

  always_comb begin
    elig[0] = req0 && (state_q != GNT0) && !full;
    elig[1] = req1 && (state_q != GNT1) && !full;
    gnt_d   = '0;
    lgp_d   = lgp_q;
    state_d = IDLE;
    case (elig)
      // Contention: favour the requester not recorded as last granted.
      2'b11: begin
        gnt_d = '{vld: 1'b1, idx: ~lgp_q};
        lgp_d = ~lgp_q;
      end
      2'b01:   gnt_d = '{vld: 1'b1, idx: 1'b0};
      2'b10:   gnt_d = '{vld: 1'b1, idx: 1'b1};
      default: gnt_d = '0;
    endcase
    if (gnt_d.vld) state_d = gnt_d.idx ? GNT1 : GNT0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      lgp_q      <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
    end else begin
      state_q    <= state_d;
      lgp_q      <= lgp_d;
      gnt0       <= gnt_d.vld && !gnt_d.idx;
      gnt1       <= gnt_d.vld &&  gnt_d.idx;
      fifo_wr_en <= gnt_d.vld;
      if (gnt_d.vld) fifo_din <= gnt_d.idx ? din1 : din0;
    end
  end

  fifo_occ_counter #(.DEPTH(DEPTH)) u_occ (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_issue   (gnt_d.vld),
    .rd_en      (rd_en),
    .any_req    (req0 || req1),
    .data_count (data_count),
    .full       (full),
    .empty      (empty),
    .fifo_rd_en (fifo_rd_en),
    .wr_err     (wr_err),
    .rd_err     (rd_err)
  );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random checks of fifo_wr_arbiter against a cycle-level
// reference model of the arbitration and occupancy rules.
module tb_fifo_wr_arbiter;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk, reset_n;
  logic          req0, req1, rd_en;
  logic [DW-1:0] din0, din1;
  logic          gnt0, gnt1, fifo_wr_en, fifo_rd_en;
  logic [DW-1:0] fifo_din;
  logic [3:0]    data_count;
  logic          full, empty, wr_err, rd_err;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .rd_en(rd_en),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_din(fifo_din),
    .data_count(data_count), .full(full), .empty(empty),
    .wr_err(wr_err), .rd_err(rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model: occupancy, who was granted last cycle (-1 none),
  // and which requester won the last contention.
  int        m_cnt, m_last, m_lgp;
  bit        e_g0, e_g1, e_wr, e_rd, e_werr, e_rerr;
  logic [DW-1:0] e_din;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt0"},  64'(gnt0), 64'(e_g0));
    chk({tag, ".gnt1"},  64'(gnt1), 64'(e_g1));
    chk({tag, ".wr_en"}, 64'(fifo_wr_en), 64'(e_wr));
    chk({tag, ".rd_en"}, 64'(fifo_rd_en), 64'(e_rd));
    chk({tag, ".din"},   64'(fifo_din), 64'(e_din));
    chk({tag, ".count"}, 64'(data_count), 64'(m_cnt));
    chk({tag, ".full"},  64'(full), 64'(m_cnt == DEPTH));
    chk({tag, ".empty"}, 64'(empty), 64'(m_cnt == 0));
    chk({tag, ".wr_err"}, 64'(wr_err), 64'(e_werr));
    chk({tag, ".rd_err"}, 64'(rd_err), 64'(e_rerr));
  endtask

  task automatic model_reset();
    m_cnt = 0; m_last = -1; m_lgp = 1;
    e_g0 = 0; e_g1 = 0; e_wr = 0; e_rd = 0; e_werr = 0; e_rerr = 0;
    e_din = '0;
  endtask

  task automatic step(input bit r0, input bit r1, input bit rd, input string tag);
    bit el0, el1, rdi;
    int g;
    req0 = r0; req1 = r1; rd_en = rd;
    el0 = r0 && (m_last != 0) && (m_cnt < DEPTH);
    el1 = r1 && (m_last != 1) && (m_cnt < DEPTH);
    g = -1;
    if (el0 && el1) begin
      g = (m_lgp == 0) ? 1 : 0;
      m_lgp = g;
    end else if (el0) g = 0;
    else if (el1) g = 1;
    rdi    = rd && (m_cnt > 0);
    e_g0   = (g == 0);
    e_g1   = (g == 1);
    e_wr   = (g >= 0);
    e_rd   = rdi;
    e_werr = (r0 || r1) && (m_cnt == DEPTH);
    e_rerr = rd && (m_cnt == 0);
    if (g == 0) e_din = din0;
    if (g == 1) e_din = din1;
    m_cnt  = m_cnt + (g >= 0 ? 1 : 0) - (rdi ? 1 : 0);
    m_last = g;
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    reset_n = 1'b0; req0 = 0; req1 = 0; rd_en = 0;
    din0 = '0; din1 = '0;
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;

    // Single requester: grants on alternate cycles, count 1,2,3.
    din0 = 32'hA5A5A5A5;
    for (int i = 0; i < 6; i++) step(1, 0, 0, "single");
    chk("single_cnt3", 64'(data_count), 64'd3);
    chk("single_din", 64'(fifo_din), 64'hA5A5A5A5);

    // Drain, then read at empty.
    for (int i = 0; i < 5; i++) step(0, 0, 1, "drain");
    chk("empty_rderr", 64'(rd_err), 64'd1);
    chk("empty_rden", 64'(fifo_rd_en), 64'd0);
    chk("empty_cnt", 64'(data_count), 64'd0);

    @(negedge clk); reset_n = 1'b0; #1;
    model_reset();
    check_all("reset2");
    reset_n = 1'b1;

    // Contention right after reset: 0,1,0,1,... until full.
    din0 = 32'h11111111; din1 = 32'h22222222;
    for (int i = 0; i < 8; i++) step(1, 1, 0, "contend");
    chk("contend_cnt8", 64'(data_count), 64'd8);
    chk("contend_full", 64'(full), 64'd1);

    // Full with a read: no write-through, error pulse, then grant.
    step(0, 1, 1, "full_rd");
    chk("full_nognt", 64'(gnt1), 64'd0);
    chk("full_werr", 64'(wr_err), 64'd1);
    chk("full_cnt7", 64'(data_count), 64'd7);
    step(0, 1, 0, "after_full");
    chk("after_full_gnt1", 64'(gnt1), 64'd1);

    // Simultaneous write and read at occupancy 5.
    while (m_cnt > 5) step(0, 0, 1, "to5");
    step(1, 0, 1, "simul");
    chk("simul_wr", 64'(fifo_wr_en), 64'd1);
    chk("simul_rd", 64'(fifo_rd_en), 64'd1);
    chk("simul_cnt5", 64'(data_count), 64'd5);

    // Reset mid-operation while gnt0 is high at occupancy 4.
    step(0, 0, 1, "to4"); step(0, 0, 1, "to4");
    step(1, 0, 0, "pre_rst");
    chk("pre_rst_gnt0", 64'(gnt0), 64'd1);
    chk("pre_rst_cnt4", 64'(data_count), 64'd4);
    #2 reset_n = 1'b0; #1;
    model_reset();
    check_all("mid_rst");
    #1 reset_n = 1'b1;
    step(1, 1, 0, "post_rst");
    chk("post_rst_gnt0", 64'(gnt0), 64'd1);

    // Random traffic; data held stable while its request stays high.
    for (int i = 0; i < 400; i++) begin
      bit r0, r1, rd;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 9) < (i < 200 ? 3 : 7));
      if (!req0) din0 = $urandom;
      if (!req1) din1 = $urandom;
      step(r0, r1, rd, "rand");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of requester and FIFO data.
REQ-002 SHALL have parameter DEPTH, default 8, capacity of the controlled FIFO in entries.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req0 and req1, input, 1 each, write request from requester 0 and requester 1.
REQ-006 SHALL have ports din0 and din1, input, DATA_WIDTH each, write data, held stable while the matching req is high.
REQ-007 SHALL have ports gnt0 and gnt1, output, 1 each, one-cycle acceptance pulse to the matching requester.
REQ-008 SHALL have port rd_en, input, 1, read request from the consumer.
REQ-009 SHALL have ports fifo_wr_en and fifo_rd_en, output, 1 each, FIFO write and read strobes.
REQ-010 SHALL have port fifo_din, output, DATA_WIDTH, data presented to the FIFO write port.
REQ-011 SHALL have port data_count, output, $clog2(DEPTH)+1, tracked occupancy from 0 to DEPTH.
REQ-012 SHALL have ports full, empty, wr_err and rd_err, output, 1 each, with the status meanings in REQ-021 to REQ-023.

Function
REQ-013 SHALL have three FSM states: IDLE (no grant last cycle), GNT0 (requester 0 granted last cycle) and GNT1 (requester 1 granted last cycle).
REQ-014 SHALL treat requester i as eligible when req_i=1, the state is not GNTi, and data_count<DEPTH.
REQ-015 SHALL, when exactly one requester is eligible, grant that requester.
REQ-016 SHALL, when both requesters are eligible, grant the one not recorded in last-grant pointer lgp, then set lgp to the granted index.
REQ-017 SHALL, on a grant to requester i, register gnt_i=1, fifo_wr_en=1, fifo_din=din_i and next state GNTi; with no grant, register gnt0=gnt1=0, fifo_wr_en=0 and next state IDLE.
REQ-018 SHALL have a latency of one cycle from the req edge sample to gnt/fifo_wr_en; at most one write issues per cycle, and a requester is never granted on two consecutive cycles.
REQ-019 SHALL register fifo_rd_en=1 when rd_en=1 and data_count>0, else 0.
REQ-020 SHALL update data_count as data_count + write issued - read issued; a simultaneous write and read leaves it unchanged.
REQ-021 SHALL drive full=(data_count==DEPTH) and empty=(data_count==0), decoded combinationally from the register.
REQ-022 SHALL block writes at full even when a read issues in the same cycle, with no write-through.
REQ-023 SHALL register a one-cycle pulse wr_err=1 when any req is high at full, and rd_err=1 when rd_en=1 at empty; neither error changes data_count.
REQ-024 SHALL hold fifo_din at its last value while fifo_wr_en=0.

Reset
REQ-025 SHALL, while reset_n=0 (asynchronously), force state=IDLE, lgp=1, data_count=0, gnt0=gnt1=0, fifo_wr_en=fifo_rd_en=0, fifo_din=0 and wr_err=rd_err=0.
REQ-026 SHALL drop any in-flight grant on reset assertion mid-operation, with no write issued; the first grant after release goes to requester 0 if both request.

Structure
REQ-027 SHALL place the state encoding (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10) and the DEPTH default in shared package fifo_ctrl_pkg.
REQ-028 SHALL implement the occupancy counter and the full/empty/error logic as sub-module fifo_occ_counter; the FSM and grant logic stay in the top module.

Verification
REQ-029 SHALL cover the single requester case: req0=1 held, din0=0xA5A5A5A5, empty -> gnt0 and fifo_wr_en on alternate cycles, fifo_din=0xA5A5A5A5, data_count increments 1,2,3.
REQ-030 SHALL cover contention: req0=req1=1 after reset -> grants alternate 0,1,0,1 with one write per cycle, and data_count reaches 8 after 8 cycles.
REQ-031 SHALL cover full: data_count=8, req1=1, rd_en=1 -> no gnt1, wr_err=1, fifo_rd_en=1, then data_count=7 and gnt1 on the next eligible cycle.
REQ-032 SHALL cover empty: data_count=0, rd_en=1 -> fifo_rd_en=0, rd_err=1 for one cycle, and data_count stays 0.
REQ-033 SHALL cover simultaneous operations: data_count=5, one grant plus rd_en=1 in the same cycle -> fifo_wr_en=fifo_rd_en=1 and data_count stays 5.
REQ-034 SHALL cover reset mid-operation: reset_n=0 while gnt0=1 and data_count=4 -> all outputs 0 and data_count=0 immediately, without waiting for a clock edge.
